// File: rtl/npc_bp.sv
// rtl/npc_bp.sv - next-PC generator with BTB and 2-bit counter branch predictor
// Optional predictor storage is enabled by defining NPC_BP_PREDICT_EN.
module npc_bp #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_stall,
  output logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [31:0]     mispred_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic            mispredict;
  logic [XLEN-1:0] if_pc_plus4;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [XLEN-1:0] next_pc;

  assign if_pc_plus4 = if_pc + PC_STEP;
  assign ex_pc_plus4 = ex_pc + PC_STEP;

  assign mispredict = ex_valid &
                      ((ex_taken != ex_pred_taken) |
                       (ex_taken & (ex_target != ex_pred_target)));
  assign flush = mispredict;

  always_comb begin
    next_pc = pred_target;
    if (mispredict) begin
      next_pc = ex_taken ? ex_target : ex_pc_plus4;
    end else if (if_stall) begin
      next_pc = if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc <= RESET_PC;
    end else begin
      if_pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

`ifdef NPC_BP_PREDICT_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]  btb_target [BTB_DEPTH];
  logic [1:0]       btb_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

  // Lookup reads the array before this edge's write, so a same-index update
  // only becomes visible on the following cycle.
  always_comb begin
    pred_taken  = if_hit & btb_ctr[if_idx][1];
    pred_target = pred_taken ? btb_target[if_idx] : if_pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        if (ex_is_jump) begin
          btb_ctr[ex_idx] <= 2'b11;
        end else if (ex_taken) begin
          btb_ctr[ex_idx] <= (btb_ctr[ex_idx] == 2'b11) ? 2'b11 : btb_ctr[ex_idx] + 2'b01;
        end else begin
          btb_ctr[ex_idx] <= (btb_ctr[ex_idx] == 2'b00) ? 2'b00 : btb_ctr[ex_idx] - 2'b01;
        end
        if (ex_taken) begin
          btb_target[ex_idx] <= ex_target;
        end
      end else if (ex_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target;
        btb_ctr[ex_idx]    <= ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end
`else
  logic unused_static;

  assign unused_static = ex_is_jump;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc_plus4;
  end
`endif

endmodule

// File: tb/tb_npc_bp.sv
// tb/tb_npc_bp.sv - directed table-driven bench for npc_bp
module tb_npc_bp;

`ifdef NPC_BP_PREDICT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_stall;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        flush;
  logic [31:0] mispred_cnt;

  int tests = 0;
  int fails = 0;

  npc_bp #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .if_stall(if_stall), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;       // {stall, ex_valid, ex_is_jump, ex_taken}
    logic [31:0] epc;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic        exp_pt_bp;
    logic [31:0] exp_tgt_bp;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ctl, input logic [31:0] epc, input logic [31:0] etgt,
                     input logic ept, input logic [31:0] eptgt, input logic ef,
                     input logic [31:0] epcx, input logic ptb, input logic [31:0] tgtb,
                     input logic [31:0] cnt);
    vec_t v;
    v.ctl = ctl; v.epc = epc; v.etgt = etgt; v.ept = ept; v.eptgt = eptgt;
    v.exp_flush = ef; v.exp_pc = epcx; v.exp_pt_bp = ptb; v.exp_tgt_bp = tgtb; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    {if_stall, ex_valid, ex_is_jump, ex_taken} = 4'b0000;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic check_pred(input string tag, input logic pt_bp, input logic [31:0] tgt_bp,
                            input logic [31:0] pc_now);
    check({tag, " pred_taken"}, {31'b0, pred_taken}, {31'b0, BP ? pt_bp : 1'b0});
    check({tag, " pred_target"}, pred_target, BP ? tgt_bp : pc_now + 32'd4);
  endtask

  initial begin
    // reset release and sequencing
    add(4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,   1'b0, 32'h4,        1'b0, 32'h8,        32'd0);
    add(4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,   1'b0, 32'h8,        1'b0, 32'hC,        32'd0);
    // cold taken branch at 0x10
    add(4'b0101, 32'h10,       32'h40,       1'b0, 32'h0,   1'b1, 32'h40,       1'b0, 32'h44,       32'd1);
    // not-taken mispredict redirects to ex_pc+4 = 0x10
    add(4'b0100, 32'hC,        32'h0,        1'b1, 32'h10,  1'b1, 32'h10,       1'b1, 32'h40,       32'd2);
    // counter training under stall: T, T, NT, NT
    add(4'b1101, 32'h10,       32'h40,       1'b1, 32'h40,  1'b0, 32'h10,       1'b1, 32'h40,       32'd2);
    add(4'b1101, 32'h10,       32'h40,       1'b1, 32'h40,  1'b0, 32'h10,       1'b1, 32'h40,       32'd2);
    add(4'b1100, 32'h10,       32'h0,        1'b0, 32'h0,   1'b0, 32'h10,       1'b1, 32'h40,       32'd2);
    add(4'b1100, 32'h10,       32'h0,        1'b0, 32'h0,   1'b0, 32'h10,       1'b0, 32'h14,       32'd2);
    // target mismatch while stalled: redirect wins
    add(4'b1101, 32'h10,       32'h80,       1'b1, 32'h40,  1'b1, 32'h80,       1'b0, 32'h84,       32'd3);
    add(4'b0100, 32'hC,        32'h0,        1'b1, 32'h10,  1'b1, 32'h10,       1'b1, 32'h80,       32'd4);
    // alias 0x50 replaces 0x10 at index 4
    add(4'b1101, 32'h50,       32'h200,      1'b0, 32'h0,   1'b1, 32'h200,      1'b0, 32'h204,      32'd5);
    add(4'b0100, 32'hC,        32'h0,        1'b1, 32'h10,  1'b1, 32'h10,       1'b0, 32'h14,       32'd6);
    add(4'b0100, 32'h4C,       32'h0,        1'b1, 32'h0,   1'b1, 32'h50,       1'b1, 32'h200,      32'd7);
    add(4'b1100, 32'h50,       32'h0,        1'b0, 32'h0,   1'b0, 32'h50,       1'b0, 32'h54,       32'd7);
    // jump forces strongly taken
    add(4'b1111, 32'h50,       32'h300,      1'b1, 32'h300, 1'b0, 32'h50,       1'b1, 32'h300,      32'd7);
    // address wrap
    add(4'b1101, 32'h0,        32'hFFFF_FFFC, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'd8);
    add(4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'd8);
    add(4'b1100, 32'hFFFF_FFFC, 32'h0,       1'b1, 32'h0,   1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'd9);

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("reset if_pc", if_pc, 32'h0);
    check("reset pred_taken", {31'b0, pred_taken}, 32'h0);
    check("reset pred_target", pred_target, 32'h4);
    check("reset mispred_cnt", mispred_cnt, 32'h0);
    check("reset flush", {31'b0, flush}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      {if_stall, ex_valid, ex_is_jump, ex_taken} = vecs[i].ctl;
      ex_pc = vecs[i].epc; ex_target = vecs[i].etgt;
      ex_pred_taken = vecs[i].ept; ex_pred_target = vecs[i].eptgt;
      #1;
      check($sformatf("row%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
      @(posedge clk);
      #1;
      check($sformatf("row%0d if_pc", i), if_pc, vecs[i].exp_pc);
      check($sformatf("row%0d mispred_cnt", i), mispred_cnt, vecs[i].exp_cnt);
      check_pred($sformatf("row%0d", i), vecs[i].exp_pt_bp, vecs[i].exp_tgt_bp, vecs[i].exp_pc);
    end

    // predicted fetch flow from 0x0: BTB entry redirects, static config steps by 4
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("predicted fetch if_pc", if_pc, BP ? 32'hFFFF_FFFC : 32'h4);
    check("predicted fetch flush", {31'b0, flush}, 32'h0);

    // reset asserted in the middle of an update: applies immediately, update discarded
    @(negedge clk);
    {if_stall, ex_valid, ex_is_jump, ex_taken} = 4'b0101;
    ex_pc = 32'h10; ex_target = 32'h40; ex_pred_taken = 1'b0; ex_pred_target = '0;
    #1 rst_n = 1'b0;
    #1;
    check("async reset if_pc", if_pc, 32'h0);
    check("async reset mispred_cnt", mispred_cnt, 32'h0);
    check("async reset pred_taken", {31'b0, pred_taken}, 32'h0);
    check("async reset pred_target", pred_target, 32'h4);
    @(posedge clk);
    #1;
    check("in reset if_pc", if_pc, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("post reset pred_taken", {31'b0, pred_taken}, 32'h0);
    @(posedge clk);
    #1;
    check("post reset if_pc", if_pc, 32'h4);
    @(negedge clk);
    ex_pc = 32'hC; ex_valid = 1'b1; ex_pred_taken = 1'b1; ex_pred_target = 32'h10;
    @(posedge clk);
    #1;
    check("post reset redirect if_pc", if_pc, 32'h10);
    check("post reset no stale entry", {31'b0, pred_taken}, 32'h0);
    check("post reset mispred_cnt", mispred_cnt, 32'd1);
    @(negedge clk);
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
